capture_ctrl: RTL and testbench

Capture sequencer for the logic analyzer's sample RAMs. Sits between the sample-rate/decimation strobe, the trigger unit and the five channel RAMqueue instances. It generates the shared write enable and circular write address, holds off trigger qualification until enough pre-trigger samples are stored, stops after `trig_pos` post-trigger samples, and hands the buffer to cmd_cfg for dump via `set_capture_done` and the final `waddr`.

---
 rtl/capture_ctrl_if.sv | 25 ++
 rtl/capture_ctrl.sv | 113 +++++++++++
 tb/tb_capture_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/capture_ctrl_if.sv
// rtl/capture_ctrl_if.sv - capture sequencer bus between cmd_cfg/trigger unit and capture_ctrl
interface capture_ctrl_if #(
  parameter int LOG2 = 9
);
  logic            run;
  logic            capture_done;
  logic            wrt_smpl;
  logic            triggered;
  logic [LOG2-1:0] trig_pos;
  logic            we;
  logic [LOG2-1:0] waddr;
  logic            armed;
  logic            capture_en;
  logic            set_capture_done;

  modport master (
    output run, capture_done, wrt_smpl, triggered, trig_pos,
    input  we, waddr, armed, capture_en, set_capture_done
  );

  modport slave (
    input  run, capture_done, wrt_smpl, triggered, trig_pos,
    output we, waddr, armed, capture_en, set_capture_done
  );
endinterface

// File: rtl/capture_ctrl.sv
// rtl/capture_ctrl.sv - capture sequencer: shared RAM write enable, circular address, arming and stop
module capture_ctrl #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic           clk_i,
  input  logic           rst_i,
  capture_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE, DUMP} state_t;

  localparam logic [LOG2-1:0] LAST_ADDR = LOG2'(ENTRIES - 1);
  localparam logic [LOG2:0]   ENTRIES_W = (LOG2 + 1)'(ENTRIES);

  state_t          state_q, state_d;
  logic [LOG2-1:0] waddr_q, waddr_d;
  logic [LOG2:0]   smpl_cnt_q, smpl_cnt_d;
  logic [LOG2-1:0] trig_cnt_q, trig_cnt_d;
  logic            armed_q, armed_d;
  logic            capture_en_q, capture_en_d;
  logic            set_done_q, set_done_d;

  logic [LOG2-1:0] tp;
  logic            finish;
  logic [LOG2-1:0] waddr_inc;
  logic [LOG2:0]   smpl_cnt_inc;
  logic [LOG2:0]   arm_sum;

  // Post-trigger depth larger than the ring would overwrite the trigger point.
  assign tp = ({1'b0, bus.trig_pos} >= ENTRIES_W) ? LAST_ADDR : bus.trig_pos;

  assign finish       = armed_q && bus.triggered && (trig_cnt_q == tp);
  assign waddr_inc    = (waddr_q == LAST_ADDR) ? '0 : waddr_q + 1'b1;
  assign smpl_cnt_inc = (smpl_cnt_q == ENTRIES_W) ? smpl_cnt_q : smpl_cnt_q + 1'b1;
  assign arm_sum      = smpl_cnt_inc + {1'b0, tp};

  // Finish has priority over a coincident strobe, so that sample is dropped.
  assign bus.we = !rst_i && (state_q == CAPTURE) && !finish && bus.wrt_smpl;

  always_comb begin
    state_d      = state_q;
    waddr_d      = waddr_q;
    smpl_cnt_d   = smpl_cnt_q;
    trig_cnt_d   = trig_cnt_q;
    armed_d      = armed_q;
    set_done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.run && !bus.capture_done) begin
          state_d    = CAPTURE;
          waddr_d    = '0;
          smpl_cnt_d = '0;
          trig_cnt_d = '0;
          armed_d    = 1'b0;
        end
      end
      CAPTURE: begin
        if (finish) begin
          state_d    = DONE;
          set_done_d = 1'b1;
        end else if (bus.wrt_smpl) begin
          waddr_d    = waddr_inc;
          smpl_cnt_d = smpl_cnt_inc;
          if (armed_q && bus.triggered) begin
            trig_cnt_d = trig_cnt_q + 1'b1;
          end
          if (arm_sum >= ENTRIES_W) begin
            armed_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.capture_done) begin
          state_d = DUMP;
        end
      end
      DUMP: begin
        if (!bus.capture_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    capture_en_d = (state_d == CAPTURE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      waddr_q      <= '0;
      smpl_cnt_q   <= '0;
      trig_cnt_q   <= '0;
      armed_q      <= 1'b0;
      capture_en_q <= 1'b0;
      set_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      waddr_q      <= waddr_d;
      smpl_cnt_q   <= smpl_cnt_d;
      trig_cnt_q   <= trig_cnt_d;
      armed_q      <= armed_d;
      capture_en_q <= capture_en_d;
      set_done_q   <= set_done_d;
    end
  end

  assign bus.waddr            = waddr_q;
  assign bus.armed            = armed_q;
  assign bus.capture_en       = capture_en_q;
  assign bus.set_capture_done = set_done_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb/tb_capture_ctrl.sv - scoreboard bench for capture_ctrl
module tb_capture_ctrl;

  typedef struct {
    int arm_at;
    int total;
    int post;
    int final_addr;
    int dropped;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];

  capture_ctrl_if #(.LOG2(9)) bus ();

  capture_ctrl #(.ENTRIES(384), .LOG2(9)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: follows each capture, checks every write address, and scores the capture when the done pulse appears.
  int m_addr, m_wr, m_post, m_drop, m_arm;
  bit prev_cen, prev_pulse;

  always @(negedge clk) begin
    if (rst) begin
      prev_cen   = 1'b0;
      prev_pulse = 1'b0;
    end else begin
      if (bus.capture_en && !prev_cen) begin
        m_addr = 0; m_wr = 0; m_post = 0; m_drop = 0; m_arm = -1;
      end
      if (bus.armed && m_arm < 0 && bus.capture_en) m_arm = m_wr;
      if (bus.we) begin
        check("waddr_seq", int'(bus.waddr), m_addr);
        m_addr = (m_addr == 383) ? 0 : m_addr + 1;
        m_wr++;
        if (bus.armed && bus.triggered) m_post++;
      end else if (bus.capture_en && bus.wrt_smpl) begin
        m_drop++;
      end
      if (prev_pulse) check("done_pulse_width", int'(bus.set_capture_done), 0);
      if (bus.set_capture_done) begin
        check("sb_nonempty", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          exp_t e;
          e = sb_q.pop_front();
          check("arm_at_write", m_arm, e.arm_at);
          check("total_writes", m_wr, e.total);
          check("post_trig_writes", m_post, e.post);
          check("final_waddr", int'(bus.waddr), e.final_addr);
          check("dropped_strobes", m_drop, e.dropped);
        end
      end
      prev_cen   = bus.capture_en;
      prev_pulse = bus.set_capture_done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_capture(input int tpv, input int trig_after, input int period, input exp_t e);
    int c;
    int s;
    sb_q.push_back(e);
    bus.trig_pos  = 9'(tpv);
    bus.triggered = 1'b0;
    bus.wrt_smpl  = 1'b0;
    bus.run       = 1'b1;
    tick();
    check("start_capture_en", int'(bus.capture_en), 1);
    c = 0;
    s = 0;
    while (bus.capture_en && c < 8000) begin
      bus.wrt_smpl  = ((c % period) == 0);
      bus.triggered = (s >= trig_after);
      if (bus.wrt_smpl) s++;
      tick();
      c++;
    end
    bus.wrt_smpl = 1'b0;
    check("capture_timeout", int'(bus.capture_en), 0);
    check("done_pulse", int'(bus.set_capture_done), 1);
  endtask

  task automatic handoff(input bit keep_run);
    int frozen;
    tick();
    bus.capture_done = 1'b1;
    frozen = int'(bus.waddr);
    repeat (20) begin
      bus.wrt_smpl = ~bus.wrt_smpl;
      tick();
    end
    check("dump_waddr_frozen", int'(bus.waddr), frozen);
    check("dump_capture_en", int'(bus.capture_en), 0);
    check("dump_no_pulse", int'(bus.set_capture_done), 0);
    bus.wrt_smpl = 1'b0;
    if (!keep_run) bus.run = 1'b0;
    bus.capture_done = 1'b0;
    tick();
    check("dump_to_idle", int'(bus.capture_en), 0);
    tick();
    check("restart", int'(bus.capture_en), int'(keep_run));
    if (keep_run) begin
      check("restart_waddr", int'(bus.waddr), 0);
      check("restart_armed", int'(bus.armed), 0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.run = 1'b0;
    bus.capture_done = 1'b0;
    bus.wrt_smpl = 1'b0;
    bus.triggered = 1'b0;
    bus.trig_pos = '0;
    repeat (3) tick();
    check("rst_we", int'(bus.we), 0);
    check("rst_waddr", int'(bus.waddr), 0);
    check("rst_armed", int'(bus.armed), 0);
    check("rst_capture_en", int'(bus.capture_en), 0);
    check("rst_set_done", int'(bus.set_capture_done), 0);
    rst = 1'b0;
    tick();

    // Reset in the middle of a capture.
    bus.trig_pos = 9'd10;
    bus.run = 1'b1;
    tick();
    check("mid_start", int'(bus.capture_en), 1);
    repeat (50) begin
      bus.wrt_smpl = 1'b1;
      tick();
    end
    check("mid_waddr_50", int'(bus.waddr), 50);
    rst = 1'b1;
    bus.run = 1'b0;
    @(negedge clk);
    check("mid_rst_no_write", int'(bus.we), 0);
    tick();
    rst = 1'b0;
    bus.wrt_smpl = 1'b0;
    check("mid_capture_en", int'(bus.capture_en), 0);
    check("mid_waddr", int'(bus.waddr), 0);
    check("mid_armed", int'(bus.armed), 0);
    check("mid_we", int'(bus.we), 0);
    tick();

    run_capture(10, 0, 1, '{374, 384, 10, 0, 1});
    handoff(1'b0);
    run_capture(100, 1000, 4, '{284, 1100, 100, 332, 0});
    handoff(1'b0);
    run_capture(0, 0, 1, '{384, 384, 0, 0, 1});
    handoff(1'b0);
    run_capture(400, 0, 1, '{1, 384, 383, 0, 1});
    handoff(1'b1);

    rst = 1'b1;
    bus.run = 1'b0;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
